uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Transmit engine downstream of the APB register interface: accepts a byte from the THR/TX-FIFO,
//  serialises it as start/data/parity/stop bits on txd per the LCR fields, timed from DLL/DLH.
//  Feeds back tsr_load and shift_cnt_eq so the register block can update THRE/TEMT.
// PARAMETERS
//  DATA_W   8   max character width; DIV_W 16 divisor width {dlh,dll}; OS_RATE 16 ticks per bit
// PORTS
//  pclk          in   1   clock
//  presetn       in   1   async active-low reset
//  tx_data       in   8   character from THR/FIFO head
//  tx_valid      in   1   tx_data valid
//  tx_ready      out  1   engine can accept; transfer when tx_valid & tx_ready
//  wls           in   2   word length: 00=5,01=6,10=7,11=8 bits
//  stb,pen,eps,sp in  1   stop select, parity en, even parity, stick parity
//  loop          in   1   loopback: txd forced 1, stream routed to txd_int only
//  dll,dlh       in   8   divisor low/high
//  utrst         in   1   0 = transmitter held in reset
//  brk           in   1   break control (UART_TX_BREAK_EN only)
//  txd           out  1   serial output pin (idle 1)
//  txd_int       out  1   raw serial stream (loopback source)
//  tsr_load      out  1   1-cycle pulse: character moved into shift register
//  shift_cnt_eq  out  1   1-cycle pulse: last stop-bit period complete
//  tx_busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, txd=txd_int=1, tx_ready=0 until utrst=1, tsr_load=shift_cnt_eq=0, counters 0.
//  DIV={dlh,dll}. Prescaler counts DIV-1..0, emits tick; DIV=0 -> no ticks, tx_ready=0, line idle.
//  tx_ready = (state==IDLE) & utrst & (DIV!=0). Handshake cycle: tsr_load=1, tx_data and
//   wls/stb/pen/eps/sp latched; later LCR changes ignored until next character.
//  FSM: IDLE -> START (16 ticks, bit=0) -> DATA (N bits LSB first, 16 ticks each) ->
//   PARITY if pen (16 ticks) -> STOP -> IDLE. Prescaler restarted at load; start bit = 16*DIV pclk.
//  txd_int changes the cycle after handshake; first bit on txd one cycle after tsr_load.
//  Parity over N data bits: pen&~sp -> eps ? even : odd; pen&sp -> eps ? 0 : 1.
//  Stop: stb=0 -> 16 ticks; stb=1 -> 32 ticks, except wls=00 -> 24 ticks (1.5 bits).
//  shift_cnt_eq asserted in the cycle STOP completes; state is IDLE next cycle. Back-to-back:
//   tx_valid held -> next tsr_load on that IDLE cycle, no idle gap beyond one pclk.
//  Bits above N in tx_data ignored. Bit counter 3 b, tick counter 5 b; no wrap beyond STOP.
//  utrst=0 mid-frame: next cycle IDLE, txd_int=1, no shift_cnt_eq pulse, character dropped.
//  DIV changed mid-frame: takes effect at next prescaler reload; no glitch on txd.
//  loop=1: txd=1, txd_int carries frame; loop=0: txd=txd_int.
// CONFIGURATION
//  UART_TX_BREAK_EN: defined -> brk port exists; brk=1 forces txd and txd_int to 0 asynchronously
//   to FSM (FSM keeps running, frame timing unchanged). Undefined -> no brk port, no break logic.
// STRUCTURE
//  uart_pkg: tx_state_e {IDLE,START,DATA,PARITY,STOP}, WLS_5/6/7/8 encodings, OS_RATE,
//   STOP_TICKS_1/1P5/2 constants.
//  Sub-module uart_baud_gen: prescaler (dll/dlh, restart, tick out), reusable by the RX engine.
// TESTING
//  DIV=1, 8N1, send 0x55 -> tsr_load pulse; txd 0,1,0,1,0,1,0,1,0,1 each 16 cycles; shift_cnt_eq at cycle 160.
//  DIV=2, wls=00, pen=1 eps=1, stb=1, 0x1F -> 5 bits 11111, parity 1, stop 48 cycles; frame 7*32+48 = 272 cycles.
//  Stick parity sp=1 eps=0, 8 bits, 0x00 -> parity bit 1; sp=1 eps=1 -> parity 0.
//  tx_valid held with 0xA5 then 0x3C -> second tsr_load the cycle after shift_cnt_eq; no extra idle bit.
//  utrst dropped in DATA bit 3 -> txd=1 next cycle, tx_busy=0, no shift_cnt_eq; DIV=0 -> tx_ready stays 0.
//  loop=1 -> txd constant 1, txd_int carries frame; UART_TX_BREAK_EN with brk=1 -> txd=0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmit states, line-control encodings and frame timing constants
package uart_pkg;

  localparam int OS_RATE        = 16;
  localparam int STOP_TICKS_1   = 16;
  localparam int STOP_TICKS_1P5 = 24;
  localparam int STOP_TICKS_2   = 32;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  // Parity over the low N data bits; stick parity ignores the data entirely.
  function automatic logic tx_parity(input logic [7:0] data, input logic [1:0] wls,
                                     input logic eps, input logic sp);
    int   nbits;
    logic x;
    nbits = 8;
    case (wls)
      WLS_5: nbits = 5;
      WLS_6: nbits = 6;
      WLS_7: nbits = 7;
      WLS_8: nbits = 8;
    endcase
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) x = x ^ data[i];
    end
    if (sp) return ~eps;
    return eps ? x : ~x;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - character handshake between the THR/TX-FIFO and the transmit engine
interface uart_tx_serializer_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - divisor prescaler producing one tick every DIV clocks, restartable
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_i,
  input  logic             restart_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // A new divisor is only picked up at reload, so a mid-bit change never shortens a tick.
  always_comb begin
    tick_o = !restart_i && (cnt_q == '0) && (div_i != '0);
    cnt_d  = cnt_q - 1'b1;
    if (restart_i || (cnt_q == '0)) cnt_d = (div_i == '0) ? '0 : div_i - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit engine: start/data/parity/stop framing on txd
// Optional break control (brk_i) is built when UART_TX_BREAK_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic                       pclk,
  input  logic                       presetn,
  uart_tx_serializer_if.slave        tx_if,
  input  logic [1:0]                 wls_i,
  input  logic                       stb_i,
  input  logic                       pen_i,
  input  logic                       eps_i,
  input  logic                       sp_i,
  input  logic                       loop_i,
  input  logic [7:0]                 dll_i,
  input  logic [7:0]                 dlh_i,
  input  logic                       utrst_i,
`ifdef UART_TX_BREAK_EN
  input  logic                       brk_i,
`endif
  output logic                       txd_o,
  output logic                       txd_int_o,
  output logic                       tsr_load_o,
  output logic                       shift_cnt_eq_o,
  output logic                       tx_busy_o
);

  tx_state_e         state_q, state_d;
  logic [4:0]        tick_cnt_q, tick_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [1:0]        wls_q, wls_d;
  logic              stb_q, stb_d, pen_q, pen_d;
  logic              txd_int_q, txd_int_d;
  logic [DIV_W-1:0]  div;
  logic              tick, load, bit_done;
  logic [4:0]        last_tick;

  assign div            = {dlh_i, dll_i};
  assign tx_if.tx_ready = (state_q == IDLE) && utrst_i && (div != '0);
  assign load           = tx_if.tx_ready && tx_if.tx_valid;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (pclk),
    .rst_n    (presetn),
    .div_i    (div),
    .restart_i(load),
    .tick_o   (tick)
  );

  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    par_d          = par_q;
    wls_d          = wls_q;
    stb_d          = stb_q;
    pen_d          = pen_q;
    shift_cnt_eq_o = 1'b0;

    last_tick = 5'(OS_RATE - 1);
    if (state_q == STOP) begin
      if (!stb_q)              last_tick = 5'(STOP_TICKS_1 - 1);
      else if (wls_q == WLS_5) last_tick = 5'(STOP_TICKS_1P5 - 1);
      else                     last_tick = 5'(STOP_TICKS_2 - 1);
    end
    bit_done = tick && (state_q != IDLE) && (tick_cnt_q == last_tick);

    // Line control is snapshotted with the character so LCR writes mid-frame are harmless.
    if (state_q == IDLE) begin
      if (load) begin
        state_d    = START;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        shift_d    = tx_if.tx_data;
        par_d      = tx_parity(tx_if.tx_data, wls_i, eps_i, sp_i);
        wls_d      = wls_i;
        stb_d      = stb_i;
        pen_d      = pen_i;
      end
    end else if (tick) begin
      tick_cnt_d = bit_done ? 5'd0 : tick_cnt_q + 5'd1;
    end

    if (bit_done) begin
      case (state_q)
        START:  state_d = DATA;
        DATA: begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == {1'b1, wls_q}) state_d = pen_q ? PARITY : STOP;
          else                            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: state_d = STOP;
        STOP: begin
          state_d        = IDLE;
          shift_cnt_eq_o = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end

    if (!utrst_i) begin
      state_d        = IDLE;
      tick_cnt_d     = '0;
      shift_cnt_eq_o = 1'b0;
    end

    case (state_d)
      START:   txd_int_d = 1'b0;
      DATA:    txd_int_d = shift_d[0];
      PARITY:  txd_int_d = par_d;
      default: txd_int_d = 1'b1;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wls_q      <= '0;
      stb_q      <= 1'b0;
      pen_q      <= 1'b0;
      txd_int_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wls_q      <= wls_d;
      stb_q      <= stb_d;
      pen_q      <= pen_d;
      txd_int_q  <= txd_int_d;
    end
  end

  assign tsr_load_o = load;
  assign tx_busy_o  = (state_q != IDLE);

`ifdef UART_TX_BREAK_EN
  assign txd_int_o = txd_int_q & ~brk_i;
  assign txd_o     = (loop_i | txd_int_q) & ~brk_i;
`else
  assign txd_int_o = txd_int_q;
  assign txd_o     = loop_i | txd_int_q;
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer (table vectors + random frames)
module tb_uart_tx_serializer;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [1:0] wls;
  logic       stb, pen, eps, sp, lp, utrst;
  logic [7:0] dll, dlh;
  logic       txd, txd_int, tsr_load, sce, busy;
`ifdef UART_TX_BREAK_EN
  logic       brk = 1'b0;
`endif

  always #5 pclk = ~pclk;

  uart_tx_serializer_if #(.DATA_W(8)) tx_if ();

  uart_tx_serializer dut (
    .pclk          (pclk),
    .presetn       (presetn),
    .tx_if         (tx_if),
    .wls_i         (wls),
    .stb_i         (stb),
    .pen_i         (pen),
    .eps_i         (eps),
    .sp_i          (sp),
    .loop_i        (lp),
    .dll_i         (dll),
    .dlh_i         (dlh),
    .utrst_i       (utrst),
`ifdef UART_TX_BREAK_EN
    .brk_i         (brk),
`endif
    .txd_o         (txd),
    .txd_int_o     (txd_int),
    .tsr_load_o    (tsr_load),
    .shift_cnt_eq_o(sce),
    .tx_busy_o     (busy)
  );

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];
  logic cap_q[$];
  logic txdq[$];
  int   sce_seen;
  int   busy_bad;

  typedef struct {
    logic [7:0] d;
    logic [1:0] w;
    logic       s_b, p_en, e_ps, s_p, l_p;
    int         dv;
    int         len;
    int         par;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference frame: each bit value repeated for its duration in pclk cycles.
  function automatic void build_model(input logic [7:0] d, input logic [1:0] w, input logic s_b,
                                      input logic p_en, input logic e_ps, input logic s_p, input int dv);
    int   n, ones, st;
    logic par;
    exp_q.delete();
    n    = 5 + int'(w);
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    par = s_p ? !e_ps : (e_ps ? (ones % 2 == 1) : (ones % 2 == 0));
    st  = !s_b ? 16 : ((w == 2'b00) ? 24 : 32);
    for (int k = 0; k < 16 * dv; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 16 * dv; k++) exp_q.push_back(d[i]);
    if (p_en)
      for (int k = 0; k < 16 * dv; k++) exp_q.push_back(par);
    for (int k = 0; k < st * dv; k++) exp_q.push_back(1'b1);
  endfunction

  task automatic set_cfg(input logic [1:0] w, input logic s_b, input logic p_en, input logic e_ps,
                         input logic s_p, input logic l_p, input int dv);
    wls = w; stb = s_b; pen = p_en; eps = e_ps; sp = s_p; lp = l_p;
    dll = dv[7:0]; dlh = dv[15:8];
  endtask

  task automatic handshake(input string tag, input bit drive, input logic [7:0] d);
    @(negedge pclk);
    if (drive) begin
      tx_if.tx_data  = d;
      tx_if.tx_valid = 1'b1;
    end
    #1;
    chk({tag, ".tsr_load"}, tsr_load, 1);
  endtask

  task automatic capture(input bit hold, input bit scramble, input logic [7:0] next_d, input int maxc);
    bit done;
    done = 0;
    cap_q.delete(); txdq.delete(); busy_bad = 0;
    while (!done && cap_q.size() < maxc) begin
      @(negedge pclk);
      tx_if.tx_valid = hold;
      tx_if.tx_data  = next_d;
      if (scramble) begin
        wls = 2'($urandom); stb = 1'($urandom); pen = 1'($urandom);
        eps = 1'($urandom); sp = 1'($urandom);
      end
      #1;
      cap_q.push_back(txd_int);
      txdq.push_back(txd);
      if (!busy) busy_bad++;
      if (sce) done = 1;
    end
    sce_seen = done;
  endtask

  task automatic compare(input string tag, input bit lpm);
    int nbad, tbad, n;
    nbad = 0; tbad = 0;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (cap_q[i] !== exp_q[i]) nbad++;
      if (lpm ? (txdq[i] !== 1'b1) : (txdq[i] !== cap_q[i])) tbad++;
    end
    chk({tag, ".len"}, cap_q.size(), exp_q.size());
    chk({tag, ".shift_cnt_eq"}, sce_seen, 1);
    chk({tag, ".txd_int_bad_cycles"}, nbad, 0);
    chk({tag, ".txd_bad_cycles"}, tbad, 0);
    chk({tag, ".busy_low_cycles"}, busy_bad, 0);
  endtask

  task automatic idle_after(input string tag);
    @(negedge pclk);
    #1;
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".idle_txd_int"}, txd_int, 1);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] d, input logic [1:0] w, input logic s_b,
                          input logic p_en, input logic e_ps, input logic s_p, input logic l_p,
                          input int dv, input bit scramble);
    set_cfg(w, s_b, p_en, e_ps, s_p, l_p, dv);
    build_model(d, w, s_b, p_en, e_ps, s_p, dv);
    handshake(tag, 1, d);
    capture(0, scramble, d, exp_q.size() + 8);
    compare(tag, l_p);
    idle_after(tag);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int nb, idx, cnt_a, cnt_b, cnt_c, cnt_d;
    logic pb;

    vt[0] = '{8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 160, -1};
    vt[1] = '{8'h1F, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 272,  1};
    vt[2] = '{8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 176,  1};
    vt[3] = '{8'h00, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 176,  0};
    vt[4] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 160, -1};
    vt[5] = '{8'hE3, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 480,  0};
    vt[6] = '{8'hFF, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 160, -1};

    presetn = 1'b0; utrst = 1'b0;
    tx_if.tx_data = 8'h00; tx_if.tx_valid = 1'b0;
    set_cfg(2'b11, 0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge pclk);
    #1;
    chk("reset.txd", txd, 1);
    chk("reset.txd_int", txd_int, 1);
    chk("reset.tx_ready", tx_if.tx_ready, 0);
    chk("reset.tsr_load", tsr_load, 0);
    chk("reset.shift_cnt_eq", sce, 0);
    chk("reset.busy", busy, 0);
    @(negedge pclk);
    presetn = 1'b1;
    #1;
    chk("utrst0.tx_ready", tx_if.tx_ready, 0);
    utrst = 1'b1;
    #1;
    chk("utrst1.tx_ready", tx_if.tx_ready, 1);

    for (int i = 0; i < 7; i++) begin
      do_frame($sformatf("vec%0d", i), vt[i].d, vt[i].w, vt[i].s_b, vt[i].p_en, vt[i].e_ps,
               vt[i].s_p, vt[i].l_p, vt[i].dv, 0);
      chk($sformatf("vec%0d.frame_len", i), cap_q.size(), vt[i].len);
      if (vt[i].par >= 0) begin
        nb  = 5 + int'(vt[i].w);
        idx = (1 + nb) * 16 * vt[i].dv + 8 * vt[i].dv;
        pb  = (idx < cap_q.size()) ? cap_q[idx] : 1'bx;
        chk($sformatf("vec%0d.parity_bit", i), pb, vt[i].par);
      end
    end

    for (int r = 0; r < 20; r++) begin
      do_frame($sformatf("rand%0d", r), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 3), 1);
    end

    set_cfg(2'b11, 0, 0, 0, 0, 0, 1);
    build_model(8'hA5, 2'b11, 0, 0, 0, 0, 1);
    handshake("b2b1", 1, 8'hA5);
    capture(1, 0, 8'h3C, exp_q.size() + 8);
    compare("b2b1", 0);
    handshake("b2b2", 0, 8'h3C);
    chk("b2b2.line_high_at_load", txd_int, 1);
    build_model(8'h3C, 2'b11, 0, 0, 0, 0, 1);
    capture(0, 0, 8'h3C, exp_q.size() + 8);
    compare("b2b2", 0);
    idle_after("b2b2");

    handshake("urst", 1, 8'hF7);
    for (int c = 1; c <= 70; c++) begin
      @(negedge pclk);
      tx_if.tx_valid = 1'b0;
      #1;
    end
    chk("urst.data_bit3", txd_int, 0);
    @(negedge pclk);
    utrst = 1'b0;
    #1;
    chk("urst.no_shift_cnt_eq", sce, 0);
    chk("urst.tx_ready", tx_if.tx_ready, 0);
    @(negedge pclk);
    #1;
    chk("urst.txd_int", txd_int, 1);
    chk("urst.txd", txd, 1);
    chk("urst.busy", busy, 0);
    cnt_a = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge pclk);
      #1;
      if (sce || busy || !txd) cnt_a++;
    end
    chk("urst.quiet_cycles_bad", cnt_a, 0);
    utrst = 1'b1;
    #1;
    chk("urst.ready_again", tx_if.tx_ready, 1);

    dll = 8'h00; dlh = 8'h00;
    tx_if.tx_data = 8'h00; tx_if.tx_valid = 1'b1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge pclk);
      #1;
      if (tx_if.tx_ready) cnt_a++;
      if (tsr_load) cnt_b++;
      if (busy) cnt_c++;
      if (!txd) cnt_d++;
    end
    chk("div0.tx_ready_cycles", cnt_a, 0);
    chk("div0.tsr_load_cycles", cnt_b, 0);
    chk("div0.busy_cycles", cnt_c, 0);
    chk("div0.txd_low_cycles", cnt_d, 0);
    tx_if.tx_valid = 1'b0;

`ifdef UART_TX_BREAK_EN
    set_cfg(2'b11, 0, 0, 0, 0, 0, 1);
    brk = 1'b1;
    build_model(8'h5A, 2'b11, 0, 0, 0, 0, 1);
    handshake("brk", 1, 8'h5A);
    capture(0, 0, 8'h5A, exp_q.size() + 8);
    cnt_a = 0;
    for (int i = 0; i < cap_q.size(); i++) if (cap_q[i] !== 1'b0 || txdq[i] !== 1'b0) cnt_a++;
    chk("brk.high_cycles", cnt_a, 0);
    chk("brk.len", cap_q.size(), exp_q.size());
    chk("brk.shift_cnt_eq", sce_seen, 1);
    brk = 1'b0;
    idle_after("brk");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
